vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA sync generator: it consumes h_sync and v_sync pulse trains and recovers pixel_x, pixel_y and enable_pixel.
- It measures line and frame periods, checks them against nominal 640x480@60 timing, and asserts locked after consecutive good frames.
- Used as an on-chip timing monitor and loopback checker beside the generator, and as a bench-side golden checker.

---
 rtl/vga_sync_decoder.sv | 103 ++++++++++
 tb/tb_vga_sync_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and active-video flag from VGA sync trains,
// measures line/frame periods against nominal timing and reports lock and sticky errors.
module vga_sync_decoder #(
    parameter int H_RETRACE    = 96,
    parameter int H_BACK_PORCH = 48,
    parameter int H_WIDTH      = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_RETRACE    = 2,
    parameter int V_BACK_PORCH = 33,
    parameter int V_WIDTH      = 480,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       enable_pixel,
    output logic       locked,
    output logic [9:0] h_period,
    output logic [9:0] v_period,
    output logic       h_error,
    output logic       v_error
);
    localparam logic [9:0] X_FIRST = 10'(H_RETRACE + H_BACK_PORCH);
    localparam logic [9:0] X_LAST  = 10'(H_RETRACE + H_BACK_PORCH + H_WIDTH - 1);
    localparam logic [9:0] Y_FIRST = 10'(V_RETRACE + V_BACK_PORCH);
    localparam logic [9:0] Y_LAST  = 10'(V_RETRACE + V_BACK_PORCH + V_WIDTH - 1);
    localparam logic [9:0] HT      = 10'(H_TOTAL);
    localparam logic [9:0] HR      = 10'(H_RETRACE);
    localparam logic [9:0] VT      = 10'(V_TOTAL);
    localparam logic [9:0] VR      = 10'(V_RETRACE);
    localparam logic [2:0] LF      = 3'(LOCK_FRAMES);

    logic       h_q, v_q, h_seen, v_seen, frame_bad;
    logic [9:0] x_cnt, y_cnt;
    logic [2:0] good_cnt;
    logic       hf, hr, vf, vr, line_bad, frame_err, frame_ok, timeout;
    logic [9:0] h_len, v_len;
    logic [2:0] good_next;

    // h_len/v_len are the saturated "count + 1", i.e. the measured length ending on this edge
    always_comb begin
        hf        = h_q & ~h_sync_in;
        hr        = ~h_q & h_sync_in;
        vf        = v_q & ~v_sync_in;
        vr        = ~v_q & v_sync_in;
        h_len     = (x_cnt == 10'h3ff) ? x_cnt : x_cnt + 10'd1;
        v_len     = (y_cnt == 10'h3ff) ? y_cnt : y_cnt + 10'd1;
        line_bad  = h_seen & ((hf & (h_len != HT)) | (hr & (h_len != HR)));
        frame_err = v_seen & ((vf & ((v_len != VT) | ~hf | frame_bad)) | (vr & (v_len != VR)));
        frame_ok  = vf & v_seen & ~frame_err;
        timeout   = x_cnt == 10'h3ff;
        good_next = (good_cnt == 3'd7) ? good_cnt : good_cnt + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q          <= 1'b0;
            v_q          <= 1'b0;
            h_seen       <= 1'b0;
            v_seen       <= 1'b0;
            frame_bad    <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            good_cnt     <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            enable_pixel <= 1'b0;
            locked       <= 1'b0;
            h_period     <= '0;
            v_period     <= '0;
            h_error      <= 1'b0;
            v_error      <= 1'b0;
        end else begin
            h_q          <= h_sync_in;
            v_q          <= v_sync_in;
            x_cnt        <= hf ? '0 : h_len;
            y_cnt        <= vf ? '0 : hf ? v_len : y_cnt;
            pixel_x      <= x_cnt;
            pixel_y      <= y_cnt;
            enable_pixel <= locked && x_cnt >= X_FIRST && x_cnt <= X_LAST
                            && y_cnt >= Y_FIRST && y_cnt <= Y_LAST;
            if (hf) h_seen <= 1'b1;
            if (hf && h_seen) h_period <= h_len;
            if (vf) v_seen <= 1'b1;
            if (vf && v_seen) v_period <= v_len;
            // a bad line taints the frame in progress; vF starts a clean one
            frame_bad    <= line_bad | (frame_bad & ~vf);
            h_error      <= h_error | line_bad;
            v_error      <= v_error | frame_err;
            if (line_bad || frame_err || timeout) begin
                locked   <= 1'b0;
                good_cnt <= '0;
            end else if (frame_ok) begin
                good_cnt <= good_next;
                if (good_next >= LF) locked <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized sync-train stimulus with a timestamp-based reference model
// feeding a scoreboard queue; an independent monitor compares every cycle.
module tb_vga_sync_decoder;
    localparam int HR = 4, HBP = 3, HW = 10, HT = 20;
    localparam int VR = 2, VBP = 2, VW = 6, VT = 12;
    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       h_sync_in = 1'b1;
    logic       v_sync_in = 1'b1;
    logic [9:0] pixel_x, pixel_y, h_period, v_period;
    logic       enable_pixel, locked, h_error, v_error;

    vga_sync_decoder #(
        .H_RETRACE(HR), .H_BACK_PORCH(HBP), .H_WIDTH(HW), .H_TOTAL(HT),
        .V_RETRACE(VR), .V_BACK_PORCH(VBP), .V_WIDTH(VW), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .enable_pixel(enable_pixel),
        .locked(locked), .h_period(h_period), .v_period(v_period),
        .h_error(h_error), .v_error(v_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int px, py, hp, vp;
        bit en, lk, he, ve;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 0;

    // reference model state: event timestamps and counts since the last reset
    int t_now = 0;
    int anchor_x, last_hf, last_vf, hf_since, good, mq_h, mq_v, hper, vper;
    bit dirty, lck, herr, verr;

    function automatic int sat(int v);
        return v > 1023 ? 1023 : v;
    endfunction

    task automatic chk(string n, int t, int a, int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", n, t, a, e);
        end
    endtask

    task automatic drive_cycle(input bit r, input bit h, input bit v);
        exp_t e;
        int   xb, yb, len;
        bit   hf, hr, vf, vr, bl, bf, gf;
        @(negedge clk);
        reset = r;
        h_sync_in = h;
        v_sync_in = v;
        e.t = t_now;
        if (r) begin
            anchor_x = t_now; last_hf = -1; last_vf = -1; hf_since = 0;
            dirty = 0; good = 0; lck = 0; herr = 0; verr = 0;
            hper = 0; vper = 0; mq_h = 0; mq_v = 0;
            e.px = 0; e.py = 0; e.en = 0;
        end else begin
            xb = sat(t_now - 1 - anchor_x);
            yb = sat(hf_since);
            e.px = xb;
            e.py = yb;
            e.en = lck && xb >= HR + HBP && xb <= HR + HBP + HW - 1
                   && yb >= VR + VBP && yb <= VR + VBP + VW - 1;
            hf = (mq_h == 1) && !h;
            hr = (mq_h == 0) && h;
            vf = (mq_v == 1) && !v;
            vr = (mq_v == 0) && v;
            bl = 0; bf = 0; gf = 0;
            if (last_hf >= 0 && (hf || hr)) begin
                len = sat(t_now - last_hf);
                if (hf) hper = len;
                if (len != (hf ? HT : HR)) bl = 1;
            end
            if (last_vf >= 0 && (vf || vr)) begin
                len = sat(hf_since + 1);
                if (vf) begin
                    vper = len;
                    bf = len != VT || !hf || dirty;
                    gf = !bf;
                end else bf = len != VR;
            end
            dirty = bl ? 1'b1 : vf ? 1'b0 : dirty;
            if (bl || bf || xb == 1023) begin
                lck = 0;
                good = 0;
            end else if (gf) begin
                good = good < 7 ? good + 1 : 7;
                if (good >= LF) lck = 1;
            end
            herr |= bl;
            verr |= bf;
            hf_since = vf ? 0 : hf ? hf_since + 1 : hf_since;
            if (hf) begin
                last_hf = t_now;
                anchor_x = t_now;
            end
            if (vf) last_vf = t_now;
            mq_h = h;
            mq_v = v;
        end
        e.hp = hper; e.vp = vper; e.lk = lck; e.he = herr; e.ve = verr;
        sb.push_back(e);
        started = 1;
        t_now++;
    endtask

    task automatic line(int len, int hlow, bit v_first, bit v_rest);
        for (int i = 0; i < len; i++) drive_cycle(0, i >= hlow, i == 0 ? v_first : v_rest);
    endtask

    // bad_idx marks a line of bad_len clocks; voff shifts the vsync edges one clock off hsync
    task automatic frame(int nlines = VT, int vlow = VR, int bad_idx = -1, int bad_len = HT,
                         int short_idx = -1, bit voff = 0);
        bit vf0, vr0;
        for (int i = 0; i < nlines; i++) begin
            vf0 = !(i < vlow);
            vr0 = vf0;
            if (voff && i == 0) begin vf0 = 1; vr0 = 0; end
            if (voff && i == vlow) begin vf0 = 0; vr0 = 1; end
            line(i == bad_idx ? bad_len : HT, i == short_idx ? HR - 1 : HR, vf0, vr0);
        end
    endtask

    task automatic nominal(int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (started) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", t_now, 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("pixel_x", e.t, int'(pixel_x), e.px);
                    chk("pixel_y", e.t, int'(pixel_y), e.py);
                    chk("enable_pixel", e.t, int'(enable_pixel), int'(e.en));
                    chk("locked", e.t, int'(locked), int'(e.lk));
                    chk("h_period", e.t, int'(h_period), e.hp);
                    chk("v_period", e.t, int'(v_period), e.vp);
                    chk("h_error", e.t, int'(h_error), int'(e.he));
                    chk("v_error", e.t, int'(v_error), int'(e.ve));
                end
            end
        end
    end

    initial begin
        int r, n;
        repeat (3) drive_cycle(1, 1, 1);
        repeat (5) drive_cycle(0, 1, 1);
        nominal(4);
        frame(VT, VR, 5, HT + 1);
        nominal(3);
        frame(VT, VR, -1, HT, 6);
        nominal(1);
        frame(VT, VR + 1);
        nominal(1);
        frame(VT - 1);
        nominal(2);
        frame(VT, VR, -1, HT, -1, 1);
        nominal(2);
        line(HT, HR, 0, 0);
        repeat (2) drive_cycle(0, 0, 0);
        repeat (3) drive_cycle(1, 0, 0);
        drive_cycle(0, 0, 0);
        repeat (HT) drive_cycle(0, 1, 0);
        nominal(4);
        repeat (1100) drive_cycle(0, 1, 1);
        nominal(1);
        repeat (2) drive_cycle(1, 1, 1);
        nominal(3);
        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(0, 5);
            n = $urandom_range(VR + 1, VT - 3);
            case (r)
                0: frame(VT, VR, n, $urandom_range(0, 1) ? HT + 1 : HT - 1);
                1: frame(VT, VR, -1, HT, $urandom_range(0, VT - 1));
                2: frame($urandom_range(0, 1) ? VT + 1 : VT - 1);
                3: frame(VT, VR + 1);
                4: frame(VT, VR, -1, HT, -1, 1);
                default: frame();
            endcase
            nominal($urandom_range(1, 3));
        end
        @(posedge clk);
        #4;
        chk("scoreboard_drained", t_now, sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
